// File: rtl/rng_address.sv
// Free-running 16-bit Fibonacci LFSR plus a small FSM that reduces a captured
// 4-bit random value modulo a candidate count by repeated subtraction.
module rng_address (
   input  logic        clock,
   input  logic        nreset,
   input  logic        start_rng_address,
   input  logic [15:0] betterNeighborCount,
   output logic [15:0] rng_out,
   output logic [15:0] rng_out_4bit,
   output logic [15:0] rng_address_out,
   output logic        done_rng_address,
   output logic [1:0]  fsm_state
);

   // Handshake: a request is accepted on any rising edge where the FSM is IDLE
   // and start_rng_address=1; done_rng_address pulses for one cycle when
   // rng_address_out carries the new result. start is ignored outside IDLE.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   state_t      state_q, state_d;
   logic [15:0] lfsr_q;
   logic [15:0] v_q, v_d;
   logic [15:0] c_q, c_d;
   logic [15:0] addr_q, addr_d;
   logic        done_q, done_d;
   logic        feedback;

   // Taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
   assign feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         lfsr_q  <= LFSR_SEED;
         state_q <= IDLE;
         v_q     <= 16'd0;
         c_q     <= 16'd0;
         addr_q  <= 16'd0;
         done_q  <= 1'b0;
      end else begin
         lfsr_q  <= {feedback, lfsr_q[15:1]};
         state_q <= state_d;
         v_q     <= v_d;
         c_q     <= c_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      c_d     = c_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_rng_address) begin
               v_d = {12'd0, lfsr_q[3:0]};
               c_d = betterNeighborCount;
               if (betterNeighborCount == 16'd0) begin
                  // Empty candidate set: answer 0 straight away.
                  addr_d  = 16'd0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = REDUCE;
               end
            end
         end
         REDUCE: begin
            if (v_q >= c_q) begin
               v_d = v_q - c_q;
            end else begin
               addr_d  = v_q;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rng_out          = lfsr_q;
   assign rng_out_4bit     = {12'd0, lfsr_q[3:0]};
   assign rng_address_out  = addr_q;
   assign done_rng_address = done_q;
   assign fsm_state        = state_q;

endmodule

// File: tb/tb_rng_address.sv
// Directed bench for rng_address: LFSR sequence, modulo reduction, latency,
// held start, reset during an operation, and a long run of random counts.
module tb_rng_address;

   logic        clock;
   logic        nreset;
   logic        start_rng_address;
   logic [15:0] betterNeighborCount;
   logic [15:0] rng_out;
   logic [15:0] rng_out_4bit;
   logic [15:0] rng_address_out;
   logic        done_rng_address;
   logic [1:0]  fsm_state;

   int          n_cmp;
   int          n_fail;
   logic [15:0] lfsr_m;

   rng_address dut (
      .clock               (clock),
      .nreset              (nreset),
      .start_rng_address   (start_rng_address),
      .betterNeighborCount (betterNeighborCount),
      .rng_out             (rng_out),
      .rng_out_4bit        (rng_out_4bit),
      .rng_address_out     (rng_address_out),
      .done_rng_address    (done_rng_address),
      .fsm_state           (fsm_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   task automatic tick();
      @(posedge clock);
      lfsr_m = lfsr_next(lfsr_m);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      nreset = 1'b0;
      start_rng_address = 1'b0;
      betterNeighborCount = 16'd0;
      lfsr_m = 16'hACE1;
      #23;
      @(negedge clock);
      nreset = 1'b1;
   endtask

   // One request of count n, issued from IDLE; checks result, latency, pulse width.
   task automatic do_request(input logic [15:0] n, input string name);
      logic [15:0] v;
      int          lat;
      int          exp_lat;
      v = {12'd0, lfsr_m[3:0]};
      n_cmp++;
      if (rng_out !== lfsr_m) begin
         n_fail++;
         $display("FAIL %s rng_out: got %h expected %h", name, rng_out, lfsr_m);
      end
      start_rng_address = 1'b1;
      betterNeighborCount = n;
      tick();
      start_rng_address = 1'b0;
      betterNeighborCount = 16'($urandom);
      if (n == 16'd0) begin
         n_cmp++;
         if (done_rng_address !== 1'b1 || rng_address_out !== 16'd0) begin
            n_fail++;
            $display("FAIL %s n0: done=%b addr=%0d expected done=1 addr=0",
                     name, done_rng_address, rng_address_out);
         end
      end else begin
         exp_lat = v / n + 1;
         n_cmp++;
         if (done_rng_address !== 1'b0) begin
            n_fail++;
            $display("FAIL %s early_done: done=%b on capture edge expected 0", name, done_rng_address);
         end
         lat = 0;
         while (done_rng_address !== 1'b1 && lat < 20) begin
            tick();
            lat++;
         end
         n_cmp++;
         if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d (v=%0d n=%0d)", name, lat, exp_lat, v, n);
         end
         n_cmp++;
         if (rng_address_out !== v % n) begin
            n_fail++;
            $display("FAIL %s address: got %0d expected %0d (v=%0d n=%0d)",
                     name, rng_address_out, v % n, v, n);
         end
      end
      tick();
      n_cmp++;
      if (done_rng_address !== 1'b0 || fsm_state !== 2'd0) begin
         n_fail++;
         $display("FAIL %s done_drop: done=%b state=%0d expected done=0 state=0",
                  name, done_rng_address, fsm_state);
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      nreset = 1'b0;
      lfsr_m = 16'hACE1;
      #1;
      n_cmp++;
      if (rng_out !== 16'hACE1 || rng_out_4bit !== 16'h0001 || rng_address_out !== 16'd0 ||
          done_rng_address !== 1'b0 || fsm_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_values: rng=%h r4=%h addr=%h done=%b st=%0d expected ACE1 0001 0000 0 0",
                  rng_out, rng_out_4bit, rng_address_out, done_rng_address, fsm_state);
      end
      @(negedge clock);
      nreset = 1'b1;
   endtask

   task automatic test_lfsr_sequence();
      logic [15:0] exp_seq [3];
      logic [15:0] exp_4b  [3];
      exp_seq[0] = 16'hACE1; exp_seq[1] = 16'h5670; exp_seq[2] = 16'hAB38;
      exp_4b[0]  = 16'h0001; exp_4b[1]  = 16'h0000; exp_4b[2]  = 16'h0008;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (rng_out !== exp_seq[i] || rng_out_4bit !== exp_4b[i]) begin
            n_fail++;
            $display("FAIL lfsr_seq[%0d]: got %h/%h expected %h/%h",
                     i, rng_out, rng_out_4bit, exp_seq[i], exp_4b[i]);
         end
         if (i < 2) tick();
      end
      for (int i = 0; i < 200; i++) tick();
      n_cmp++;
      if (rng_out !== lfsr_m) begin
         n_fail++;
         $display("FAIL lfsr_freerun: got %h expected %h", rng_out, lfsr_m);
      end
   endtask

   task automatic test_single_request();
      do_reset();
      do_request(16'd4, "n4_first");
      n_cmp++;
      if (rng_address_out !== 16'd1) begin
         n_fail++;
         $display("FAIL n4_first_addr: got %0d expected 1", rng_address_out);
      end
   endtask

   task automatic test_worst_case();
      int guard;
      guard = 0;
      while (lfsr_m[3:0] != 4'hF && guard < 200) begin
         tick();
         guard++;
      end
      n_cmp++;
      if (lfsr_m[3:0] != 4'hF) begin
         n_fail++;
         $display("FAIL worst_nibble: no nibble 15 found within %0d cycles", guard);
      end
      do_request(16'd1, "n1_v15");
      do_request(16'd0, "n0");
   endtask

   task automatic test_back_to_back();
      int pulses;
      int idle_seen;
      int guard;
      logic prev_done;
      pulses = 0;
      idle_seen = 0;
      prev_done = 1'b0;
      betterNeighborCount = 16'd4;
      start_rng_address = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (done_rng_address === 1'b1) begin
            pulses++;
            n_cmp++;
            if (rng_address_out >= 16'd4 || prev_done === 1'b1) begin
               n_fail++;
               $display("FAIL held_pulse: addr=%0d prev_done=%b expected addr<4 and single-cycle pulse",
                        rng_address_out, prev_done);
            end
         end
         if (fsm_state === 2'd0) idle_seen++;
         prev_done = done_rng_address;
      end
      start_rng_address = 1'b0;
      n_cmp++;
      if (pulses < 5 || idle_seen < pulses - 1) begin
         n_fail++;
         $display("FAIL held_summary: pulses=%0d idle=%0d expected >=5 pulses with idle between",
                  pulses, idle_seen);
      end
      guard = 0;
      while (fsm_state !== 2'd0 && guard < 20) begin
         tick();
         guard++;
      end
      tick();
   endtask

   task automatic test_reset_mid_op();
      int guard;
      guard = 0;
      while (lfsr_m[3:0] < 4'd8 && guard < 200) begin
         tick();
         guard++;
      end
      start_rng_address = 1'b1;
      betterNeighborCount = 16'd1;
      tick();
      start_rng_address = 1'b0;
      tick();
      tick();
      #2;
      nreset = 1'b0;
      lfsr_m = 16'hACE1;
      #1;
      n_cmp++;
      if (rng_out !== 16'hACE1 || rng_address_out !== 16'd0 || done_rng_address !== 1'b0 ||
          fsm_state !== 2'd0) begin
         n_fail++;
         $display("FAIL midop_reset: rng=%h addr=%0d done=%b st=%0d expected ACE1 0 0 0",
                  rng_out, rng_address_out, done_rng_address, fsm_state);
      end
      #16;
      n_cmp++;
      if (done_rng_address !== 1'b0 || rng_out !== 16'hACE1) begin
         n_fail++;
         $display("FAIL midop_hold: done=%b rng=%h expected 0 ACE1", done_rng_address, rng_out);
      end
      #3;
      nreset = 1'b1;
      do_request(16'd4, "after_reset");
      n_cmp++;
      if (rng_address_out !== 16'd1) begin
         n_fail++;
         $display("FAIL after_reset_addr: got %0d expected 1", rng_address_out);
      end
   endtask

   task automatic test_random_counts();
      for (int i = 0; i < 1000; i++) begin
         do_request(16'($urandom_range(1, 16)), "rand");
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      nreset = 1'b1;
      start_rng_address = 1'b0;
      betterNeighborCount = 16'd0;
      lfsr_m = 16'hACE1;
      test_reset();
      test_lfsr_sequence();
      test_single_request();
      test_worst_case();
      test_back_to_back();
      test_reset_mid_op();
      test_random_counts();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rng_address.md
RNG_ADDRESS -- requirements
Module: rng_address

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clock input 1 (rising edge), nreset input 1 (active-low, asynchronous assert).
REQ-002 Port start_rng_address SHALL be input 1: request to compute one random address.
REQ-003 Port betterNeighborCount SHALL be input 16: number of candidates N; address range is 0..N-1.
REQ-004 Port rng_out SHALL be output 16: current internal LFSR state.
REQ-005 Port rng_out_4bit SHALL be output 16: {12'b0, rng_out[3:0]}.
REQ-006 Port rng_address_out SHALL be output 16: last computed address, held until the next completion.
REQ-007 Port done_rng_address SHALL be output 1: one-cycle completion pulse.

Function
REQ-008 The LFSR SHALL be a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, maximal period 65535.
REQ-009 The LFSR SHALL advance on every rising edge, independent of the FSM: next = {s[0]^s[2]^s[3]^s[5], s[15:1]}.
REQ-010 The LFSR SHALL never reach all-zero, since the seed is nonzero.
REQ-011 The address FSM SHALL have states IDLE, REDUCE and DONE.
REQ-012 IDLE, start_rng_address=1 at an edge: SHALL capture v=rng_out[3:0] (pre-update value) and c=betterNeighborCount.
REQ-012a That IDLE edge SHALL go to REDUCE when c != 0.
REQ-013 IDLE, start=1, c==0: SHALL set rng_address_out=0 and done=1, and go to DONE on that edge.
REQ-014 REDUCE, per edge:
- if v>=c: v<=v-c, stay in REDUCE (one subtraction per cycle);
- else: rng_address_out<=v, done<=1, go to DONE.
REQ-015 Result SHALL equal v mod c, 16-bit unsigned arithmetic, no overflow (v<=15).
REQ-016 Latency SHALL be floor(v/c)+1 edges from the capture edge to the edge asserting done; worst case 16 (c=1, v=15).
REQ-017 DONE: done SHALL drop to 0 on the next edge and the FSM SHALL return to IDLE; done is high for exactly one cycle.
REQ-018 start SHALL be sampled only in IDLE and ignored in REDUCE/DONE; if held high, a new request starts on the first edge back in IDLE.
REQ-019 betterNeighborCount changes after capture SHALL not affect the operation in progress.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 nreset=0 SHALL immediately (asynchronously) force:
- LFSR=16'hACE1;
- FSM=IDLE, v=0, c=0;
- rng_address_out=0, done_rng_address=0.
REQ-022 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-023 The first request after release SHALL be sampled on the first rising edge with nreset=1.
REQ-024 Reset values: rng_out=16'hACE1, rng_out_4bit=16'h0001.

Verification
REQ-025 Reset, then free-run: rng_out sequence SHALL be ACE1 -> 5670 -> AB38 on successive edges; rng_out_4bit SHALL be 1 -> 0 -> 8.
REQ-026 N=4, start=1 at release, capture v=1: rng_address_out=1 and done pulse one edge after capture.
REQ-027 N=1, v=15: done SHALL assert 16 edges after capture with address 0; N=0 -> address 0, done on the capture edge.
REQ-028 N=4, start held high for 500 time units: repeated one-cycle done pulses, every address < 4, IDLE revisited between requests.
REQ-029 nreset pulsed low for 20 time units during REDUCE:
- outputs SHALL clear immediately with no done pulse;
- LFSR SHALL restart at ACE1;
- a new request SHALL follow release.
REQ-030 Randomized N in 1..16 over 1000 requests: address SHALL equal (captured nibble mod N) and latency SHALL match REQ-016.
